// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Round-robin arbiter that gives N_REQ requesters timed, exclusive access to
//   one WIDTH-bit register. A grant lasts at most MAX_HOLD cycles and is
//   always followed by one idle cycle. Only the current holder can write the
//   register. When CLEAR_ON_SWITCH=1, the register is cleared at a grant edge
//   if the new holder is not the requester that last wrote it.
//
// Ports
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   req    : per-requester request, level-sensitive
//   we     : per-requester write enable; only the holder's bit is used
//   wdata  : packed write data; requester k uses [k*WIDTH +: WIDTH]
//   gnt    : registered one-hot grant
//   q      : register contents
//   owner  : index of the requester that last wrote q
//   busy   : high while a grant is active
module shared_reg_arbiter #(
  parameter int N_REQ           = 4,
  parameter int WIDTH           = 8,
  parameter int MAX_HOLD        = 4,
  parameter int CLEAR_ON_SWITCH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         we,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int HC_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [N_REQ-1:0]   gnt_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic [IDX_W-1:0]   owner_nxt;
  logic [IDX_W-1:0]   last_gnt, last_nxt;
  logic [HC_W-1:0]    hold_cnt, hold_nxt;

  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   cand;
  logic               found;
  logic               hold_write;
  logic               release_now;

  logic [WIDTH-1:0]   lane [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lane[g] = wdata[g*WIDTH +: WIDTH];
  end

  // Round-robin pick: first set req bit starting just after last_gnt,
  // wrapping modulo N_REQ. last_gnt itself is checked last.
  always_comb begin
    sel   = last_gnt;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((32'(last_gnt) + i) % N_REQ);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // In GRANT, last_gnt is the index of the current holder.
  assign hold_write  = req[last_gnt] & we[last_gnt];
  assign release_now = !req[last_gnt] || (hold_cnt == HC_W'(MAX_HOLD - 1));

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    q_nxt     = q;
    owner_nxt = owner;
    last_nxt  = last_gnt;
    hold_nxt  = hold_cnt;

    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt      = '0;
          gnt_nxt[sel] = 1'b1;
          last_nxt     = sel;
          hold_nxt     = '0;
          state_nxt    = GRANT;
          if ((CLEAR_ON_SWITCH != 0) && (sel != owner)) begin
            q_nxt = '0;
          end
        end
      end

      GRANT: begin
        // A write on the releasing edge still lands.
        if (hold_write) begin
          q_nxt     = lane[last_gnt];
          owner_nxt = last_gnt;
        end
        if (release_now) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + HC_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      q        <= '0;
      owner    <= '0;
      last_gnt <= IDX_W'(N_REQ - 1);
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      q        <= q_nxt;
      owner    <= owner_nxt;
      last_gnt <= last_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  assign busy = (state == GRANT);

  gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter
//   Directed-vector bench for shared_reg_arbiter with default parameters
//   (N_REQ=4, WIDTH=8, MAX_HOLD=4, CLEAR_ON_SWITCH=1).
module tb_shared_reg_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        busy;

  int total;
  int bad;

  shared_reg_arbiter #(
    .N_REQ(4),
    .WIDTH(8),
    .MAX_HOLD(4),
    .CLEAR_ON_SWITCH(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .we(we),
    .wdata(wdata),
    .gnt(gnt),
    .q(q),
    .owner(owner),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic [7:0] v);
    wdata[k*8 +: 8] = v;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    wdata = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_g;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    wdata = '0;
    #1;

    // Reset dominates even with every requester asking.
    req = 4'b1111;
    tick();
    tick();
    check("rst_gnt",   32'(gnt),   32'h0);
    check("rst_q",     32'(q),     32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    rst = 1'b0;
    tick();
    check("first_gnt",  32'(gnt),  32'h1);
    check("first_busy", 32'(busy), 32'h1);

    // Single requester write.
    do_reset();
    req = 4'b0100;
    we  = 4'b0100;
    set_lane(2, 8'hA5);
    tick();
    check("sw_gnt",   32'(gnt), 32'h4);
    check("sw_q_pre", 32'(q),   32'h0);
    tick();
    check("sw_q",     32'(q),     32'hA5);
    check("sw_owner", 32'(owner), 32'h2);

    // Hold limit: 4 cycles granted, 1 idle, repeating.
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 15; i++) begin
      tick();
      exp_g = ((i % 5) != 4) ? 4'b0010 : 4'b0000;
      check($sformatf("hold_%0d", i), 32'(gnt), 32'(exp_g));
    end

    // Round-robin with all requesting: 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 25; i++) begin
      tick();
      exp_g = ((i % 5) != 4) ? (4'b0001 << ((i / 5) % 4)) : 4'b0000;
      check($sformatf("rr_%0d", i), 32'(gnt), 32'(exp_g));
    end

    // Scrub on switch and masking of non-holder writes.
    do_reset();
    req = 4'b0001;
    we  = 4'b0001;
    set_lane(0, 8'h3C);
    tick();
    check("sc_gnt0", 32'(gnt), 32'h1);
    tick();
    check("sc_q3c", 32'(q), 32'h3C);
    req = 4'b1000;
    we  = 4'b0001;
    tick();
    check("sc_rel_gnt", 32'(gnt),  32'h0);
    check("sc_rel_bsy", 32'(busy), 32'h0);
    check("sc_rel_q",   32'(q),    32'h3C);
    tick();
    check("sc_gnt3",  32'(gnt), 32'h8);
    check("sc_scrub", 32'(q),   32'h0);
    req = 4'b1001;
    we  = 4'b0001;
    set_lane(0, 8'h55);
    tick();
    check("sc_mask_q",   32'(q),     32'h0);
    check("sc_mask_own", 32'(owner), 32'h0);
    tick();
    check("sc_mask_q2", 32'(q), 32'h0);

    // Re-granting the last writer keeps q.
    do_reset();
    req = 4'b0001;
    we  = 4'b0001;
    set_lane(0, 8'h3C);
    tick();
    tick();
    req = 4'b0000;
    we  = 4'b0000;
    tick();
    check("keep_idle", 32'(busy), 32'h0);
    req = 4'b0001;
    tick();
    check("keep_gnt", 32'(gnt), 32'h1);
    check("keep_q",   32'(q),   32'h3C);

    // Reset mid-tenure discards the in-flight write.
    do_reset();
    req = 4'b0100;
    we  = 4'b0000;
    tick();
    check("mr_gnt", 32'(gnt), 32'h4);
    we = 4'b0100;
    set_lane(2, 8'hFF);
    rst = 1'b1;
    tick();
    check("mr_q",     32'(q),     32'h0);
    check("mr_gnt0",  32'(gnt),   32'h0);
    check("mr_busy",  32'(busy),  32'h0);
    check("mr_owner", 32'(owner), 32'h0);
    rst = 1'b0;
    req = 4'b0000;
    we  = 4'b0000;
    tick();
    check("mr_q_after", 32'(q), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
